// File: rtl/axi_rd_arbiter.sv
// Read-port arbiter: icache, dcache and uncached loads share one AXI3 AR/R port.
// One transaction in flight; dcache > uncache > icache with an icache starvation guard.
module axi_rd_arbiter #(
    parameter int LINE_BEATS = 16,
    parameter int MAX_CONSEC = 4
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic        ic_rd_req,
    input  logic [31:0] ic_rd_addr,
    output logic        ic_rd_rdy,
    output logic        ic_ret_valid,
    output logic        ic_ret_last,
    output logic [31:0] ic_ret_data,

    input  logic        dc_rd_req,
    input  logic [31:0] dc_rd_addr,
    output logic        dc_rd_rdy,
    output logic        dc_ret_valid,
    output logic        dc_ret_last,
    output logic [31:0] dc_ret_data,

    input  logic        uc_rd_req,
    input  logic [31:0] uc_rd_addr,
    input  logic [2:0]  uc_rd_size,
    output logic        uc_rd_rdy,
    output logic        uc_ret_valid,
    output logic [31:0] uc_ret_data,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic        rd_err
);

    localparam int CW = $clog2(MAX_CONSEC + 1);
    localparam logic [CW-1:0] SAT = CW'(MAX_CONSEC);
    localparam logic [3:0] LINE_LEN = 4'(LINE_BEATS - 1);
    localparam logic [1:0] ID_IC = 2'd0;
    localparam logic [1:0] ID_DC = 2'd1;
    localparam logic [1:0] ID_UC = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t        state_q;
    logic [1:0]    gnt_q;
    logic [1:0]    gnt_d;
    logic [CW-1:0] starve_q;
    logic [CW-1:0] starve_d;
    logic [3:0]    beat_q;
    logic [3:0]    arid_q;
    logic [31:0]   araddr_q;
    logic [3:0]    arlen_q;
    logic [2:0]    arsize_q;
    logic [1:0]    arburst_q;
    logic          arvalid_q;
    logic          rready_q;
    logic          err_q;

    logic any_req;
    logic ic_force;
    logic beat;
    logic id_ok;
    logic fwd;
    logic ar_hs;

    assign any_req  = ic_rd_req | dc_rd_req | uc_rd_req;
    assign ic_force = ic_rd_req && (starve_q == SAT);

    always_comb begin
        gnt_d = ID_IC;
        if (ic_force) begin
            gnt_d = ID_IC;
        end else if (dc_rd_req) begin
            gnt_d = ID_DC;
        end else if (uc_rd_req) begin
            gnt_d = ID_UC;
        end
    end

    // Count only dc/uc wins that happen while icache is left waiting.
    always_comb begin
        starve_d = starve_q;
        if ((gnt_d == ID_IC) || !ic_rd_req) begin
            starve_d = '0;
        end else if (starve_q != SAT) begin
            starve_d = starve_q + CW'(1);
        end
    end

    assign ar_hs = arvalid_q & arready;
    assign beat  = rvalid & rready_q;
    assign id_ok = (rid == {2'b00, gnt_q});
    assign fwd   = beat & id_ok;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            starve_q  <= '0;
            beat_q    <= '0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q   <= ADDR;
                        gnt_q     <= gnt_d;
                        starve_q  <= starve_d;
                        arid_q    <= {2'b00, gnt_d};
                        arburst_q <= 2'b01;
                        arvalid_q <= 1'b1;
                        if (gnt_d == ID_UC) begin
                            araddr_q <= uc_rd_addr;
                            arlen_q  <= 4'd0;
                            arsize_q <= uc_rd_size;
                        end else begin
                            araddr_q <= (gnt_d == ID_DC) ? dc_rd_addr
                                                         : ic_rd_addr;
                            arlen_q  <= LINE_LEN;
                            arsize_q <= 3'd2;
                        end
                    end
                end
                ADDR: begin
                    if (arready) begin
                        state_q   <= DATA;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        beat_q    <= '0;
                    end
                end
                DATA: begin
                    if (beat) begin
                        if (!id_ok) begin
                            err_q <= 1'b1;
                        end else begin
                            beat_q <= beat_q + 4'd1;
                            if (rresp != 2'b00) begin
                                err_q <= 1'b1;
                            end
                            if (rlast) begin
                                state_q  <= IDLE;
                                rready_q <= 1'b0;
                                if (beat_q != arlen_q) begin
                                    err_q <= 1'b1;
                                end
                            end else if (beat_q == arlen_q) begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign arid    = arid_q;
    assign araddr  = araddr_q;
    assign arlen   = arlen_q;
    assign arsize  = arsize_q;
    assign arburst = arburst_q;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;
    assign rd_err  = err_q;

    assign ic_rd_rdy = ar_hs & (gnt_q == ID_IC);
    assign dc_rd_rdy = ar_hs & (gnt_q == ID_DC);
    assign uc_rd_rdy = ar_hs & (gnt_q == ID_UC);

    assign ic_ret_valid = fwd & (gnt_q == ID_IC);
    assign dc_ret_valid = fwd & (gnt_q == ID_DC);
    assign uc_ret_valid = fwd & (gnt_q == ID_UC);

    assign ic_ret_last = ic_ret_valid & rlast;
    assign dc_ret_last = dc_ret_valid & rlast;

    assign ic_ret_data = ic_ret_valid ? rdata : '0;
    assign dc_ret_data = dc_ret_valid ? rdata : '0;
    assign uc_ret_data = uc_ret_valid ? rdata : '0;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: bursts, priority/starvation order,
// delayed arready, throttled R, wrong-id beat and mid-burst reset.
module tb_axi_rd_arbiter;

    logic        aclk;
    logic        aresetn;
    logic        ic_rd_req, dc_rd_req, uc_rd_req;
    logic [31:0] ic_rd_addr, dc_rd_addr, uc_rd_addr;
    logic [2:0]  uc_rd_size;
    logic        ic_rd_rdy, dc_rd_rdy, uc_rd_rdy;
    logic        ic_ret_valid, dc_ret_valid, uc_ret_valid;
    logic        ic_ret_last, dc_ret_last;
    logic [31:0] ic_ret_data, dc_ret_data, uc_ret_data;
    logic [3:0]  arid, arlen;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic        rd_err;

    int checks = 0;
    int failures = 0;

    axi_rd_arbiter dut (
        .aclk(aclk), .aresetn(aresetn),
        .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr),
        .ic_rd_rdy(ic_rd_rdy), .ic_ret_valid(ic_ret_valid),
        .ic_ret_last(ic_ret_last), .ic_ret_data(ic_ret_data),
        .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr),
        .dc_rd_rdy(dc_rd_rdy), .dc_ret_valid(dc_ret_valid),
        .dc_ret_last(dc_ret_last), .dc_ret_data(dc_ret_data),
        .uc_rd_req(uc_rd_req), .uc_rd_addr(uc_rd_addr),
        .uc_rd_size(uc_rd_size), .uc_rd_rdy(uc_rd_rdy),
        .uc_ret_valid(uc_ret_valid), .uc_ret_data(uc_ret_data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready), .rd_err(rd_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic [10:0] ctl;
    assign ctl = {arvalid, rready, rd_err, ic_rd_rdy, dc_rd_rdy, uc_rd_rdy,
                  ic_ret_valid, ic_ret_last, dc_ret_valid, dc_ret_last,
                  uc_ret_valid};

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input int id);
        case (id)
            0: return ic_rd_addr;
            1: return dc_rd_addr;
            default: return uc_rd_addr;
        endcase
    endfunction

    task automatic wait_ar();
        int n = 0;
        while (!arvalid && n < 20) begin
            @(negedge aclk); #1; n++;
        end
    endtask

    task automatic ar_phase(input int dly, input logic [3:0] eid,
                            input logic [31:0] ea, input logic [3:0] el,
                            input logic [2:0] es);
        logic [2:0] exp_rdy;
        wait_ar();
        chk("arvalid", 32'(arvalid), 1);
        chk("arid", 32'(arid), 32'(eid));
        chk("araddr", araddr, ea);
        chk("arlen", 32'(arlen), 32'(el));
        chk("arsize", 32'(arsize), 32'(es));
        chk("arburst", 32'(arburst), 1);
        for (int k = 0; k < dly; k++) begin
            @(negedge aclk); #1;
            chk("ar_hold_addr", araddr, ea);
            chk("ar_hold_valid", 32'(arvalid), 1);
            chk("rdy_early", 32'({uc_rd_rdy, dc_rd_rdy, ic_rd_rdy}), 0);
        end
        arready = 1'b1;
        #1;
        exp_rdy = 3'b001 << eid;
        chk("rdy_pulse", 32'({uc_rd_rdy, dc_rd_rdy, ic_rd_rdy}),
            32'(exp_rdy));
        @(negedge aclk);
        arready = 1'b0;
        case (eid)
            4'd0: ic_rd_req = 1'b0;
            4'd1: dc_rd_req = 1'b0;
            default: uc_rd_req = 1'b0;
        endcase
        #1;
        chk("rdy_off", 32'({uc_rd_rdy, dc_rd_rdy, ic_rd_rdy}), 0);
        chk("rready_on", 32'(rready), 1);
    endtask

    task automatic r_phase(input logic [3:0] id, input int n,
                           input bit toggle, input int bad_at,
                           output int c_ic, output int c_dc,
                           output int c_uc, output int c_last);
        int  i = 0;
        int  cyc = 0;
        bit  bad_done = 0;
        bit  good;
        logic [31:0] gdata;
        logic        glast;
        c_ic = 0; c_dc = 0; c_uc = 0; c_last = 0;
        while (i < n && cyc < 200) begin
            @(negedge aclk);
            good = 0;
            if (toggle && (cyc % 2 == 1)) begin
                rvalid = 1'b0;
                rlast  = 1'b0;
            end else if (i == bad_at && !bad_done) begin
                rvalid = 1'b1;
                rid    = id + 4'd1;
                rdata  = 32'hDEAD_BEEF;
                rlast  = 1'b0;
                bad_done = 1;
            end else begin
                rvalid = 1'b1;
                rid    = id;
                rdata  = 32'hC0DE_0000 + 32'(id) * 32'h100 + 32'(i);
                rlast  = (i == n - 1);
                good   = 1;
            end
            #1;
            c_ic += int'(ic_ret_valid);
            c_dc += int'(dc_ret_valid);
            c_uc += int'(uc_ret_valid);
            c_last += int'(ic_ret_last) + int'(dc_ret_last);
            if (bad_done && !good && rvalid && rid != id) begin
                chk("drop_bad_id",
                    32'({ic_ret_valid, dc_ret_valid, uc_ret_valid}), 0);
            end
            if (good) begin
                case (id)
                    4'd0: begin gdata = ic_ret_data; glast = ic_ret_last; end
                    4'd1: begin gdata = dc_ret_data; glast = dc_ret_last; end
                    default: begin gdata = uc_ret_data; glast = rlast; end
                endcase
                chk("ret_data", gdata, 32'hC0DE_0000 + 32'(id) * 32'h100
                                       + 32'(i));
                chk("ret_last", 32'(glast), 32'(i == n - 1));
                i++;
            end
            cyc++;
        end
        chk("r_done", 32'(i), 32'(n));
        @(negedge aclk);
        rvalid = 1'b0;
        rlast  = 1'b0;
        #1;
        chk("rready_off", 32'(rready), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    int c_ic, c_dc, c_uc, c_last;
    int order [5];
    logic [3:0] len_of;

    initial begin
        order = '{1, 2, 1, 2, 0};
        aresetn = 1'b0;
        ic_rd_req = 0; dc_rd_req = 0; uc_rd_req = 0;
        ic_rd_addr = 0; dc_rd_addr = 0; uc_rd_addr = 0; uc_rd_size = 0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        repeat (3) @(negedge aclk);
        #1;
        chk("rst_ctl", 32'(ctl), 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arlen", 32'({arid, arlen, arsize, arburst}), 0);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;

        // 1: dcache line refill
        @(negedge aclk);
        dc_rd_addr = 32'h1FC0_0040;
        dc_rd_req  = 1'b1;
        #1;
        chk("lat_arvalid0", 32'(arvalid), 0);
        @(negedge aclk); #1;
        chk("lat_arvalid1", 32'(arvalid), 1);
        ar_phase(0, 4'd1, 32'h1FC0_0040, 4'd15, 3'd2);
        r_phase(4'd1, 16, 0, -1, c_ic, c_dc, c_uc, c_last);
        chk("t1_dc_cnt", 32'(c_dc), 16);
        chk("t1_other_cnt", 32'(c_ic + c_uc), 0);
        chk("t1_last_cnt", 32'(c_last), 1);
        chk("t1_err", 32'(rd_err), 0);

        // 2: priority with icache starvation guard
        @(negedge aclk);
        ic_rd_addr = 32'h0000_2000;
        dc_rd_addr = 32'h0000_3000;
        uc_rd_addr = 32'h0000_4004;
        uc_rd_size = 3'd2;
        ic_rd_req = 1; dc_rd_req = 1; uc_rd_req = 1;
        #1;
        for (int k = 0; k < 5; k++) begin
            wait_ar();
            chk("t2_order", 32'(arid), 32'(order[k]));
            if (k > 0 && k < 4) begin
                case (order[k-1])
                    1: dc_rd_req = 1'b1;
                    2: uc_rd_req = 1'b1;
                    default: ic_rd_req = 1'b1;
                endcase
            end else if (k == 4) begin
                dc_rd_req = 1'b0;
                uc_rd_req = 1'b0;
            end
            len_of = (order[k] == 2) ? 4'd0 : 4'd15;
            ar_phase(0, 4'(order[k]), addr_of(order[k]), len_of,
                     3'd2);
            r_phase(4'(order[k]), (order[k] == 2) ? 1 : 16, 0, -1,
                    c_ic, c_dc, c_uc, c_last);
            chk("t2_cnt", 32'(c_ic + c_dc + c_uc),
                (order[k] == 2) ? 1 : 16);
        end
        repeat (2) @(negedge aclk);
        #1;
        chk("t2_quiet", 32'(arvalid), 0);

        // 3: uncached halfword, arready delayed
        @(negedge aclk);
        uc_rd_addr = 32'hBFAF_8002;
        uc_rd_size = 3'd1;
        uc_rd_req  = 1'b1;
        #1;
        ar_phase(3, 4'd2, 32'hBFAF_8002, 4'd0, 3'd1);
        r_phase(4'd2, 1, 0, -1, c_ic, c_dc, c_uc, c_last);
        chk("t3_uc_cnt", 32'(c_uc), 1);
        chk("t3_other_cnt", 32'(c_ic + c_dc), 0);

        // 4: icache burst with throttled R
        @(negedge aclk);
        ic_rd_addr = 32'h0000_1000;
        ic_rd_req  = 1'b1;
        #1;
        ar_phase(0, 4'd0, 32'h0000_1000, 4'd15, 3'd2);
        r_phase(4'd0, 16, 1, -1, c_ic, c_dc, c_uc, c_last);
        chk("t4_ic_cnt", 32'(c_ic), 16);
        chk("t4_other_cnt", 32'(c_dc + c_uc), 0);
        chk("t4_last_cnt", 32'(c_last), 1);
        chk("t4_err", 32'(rd_err), 0);

        // 5: wrong-id beat inside a dcache burst
        @(negedge aclk);
        dc_rd_addr = 32'h1FC0_0080;
        dc_rd_req  = 1'b1;
        #1;
        ar_phase(0, 4'd1, 32'h1FC0_0080, 4'd15, 3'd2);
        chk("t5_err_pre", 32'(rd_err), 0);
        r_phase(4'd1, 16, 0, 5, c_ic, c_dc, c_uc, c_last);
        chk("t5_dc_cnt", 32'(c_dc), 16);
        chk("t5_err", 32'(rd_err), 1);
        repeat (3) @(negedge aclk);
        #1;
        chk("t5_err_sticky", 32'(rd_err), 1);
        chk("t5_idle", 32'(arvalid | rready), 0);

        // 6: reset mid icache burst
        @(negedge aclk);
        ic_rd_addr = 32'h0000_5000;
        ic_rd_req  = 1'b1;
        #1;
        ar_phase(0, 4'd0, 32'h0000_5000, 4'd15, 3'd2);
        c_ic = 0;
        for (int b = 0; b < 7; b++) begin
            @(negedge aclk);
            rvalid = 1'b1; rid = 4'd0; rdata = 32'(b); rlast = 1'b0;
            #1;
            c_ic += int'(ic_ret_valid);
        end
        chk("t6_pre_cnt", 32'(c_ic), 7);
        @(negedge aclk);
        rdata = 32'd7;
        aresetn = 1'b0;
        @(negedge aclk);
        #1;
        chk("t6_rst_ctl", 32'(ctl), 0);
        chk("t6_rst_data", ic_ret_data | dc_ret_data | uc_ret_data, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        rvalid = 1'b0;
        dc_rd_addr = 32'h1FC0_00C0;
        dc_rd_req  = 1'b1;
        #1;
        ar_phase(0, 4'd1, 32'h1FC0_00C0, 4'd15, 3'd2);
        r_phase(4'd1, 16, 0, -1, c_ic, c_dc, c_uc, c_last);
        chk("t6_dc_cnt", 32'(c_dc), 16);
        chk("t6_err", 32'(rd_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
